// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ byte streams onto one UART TX input.
// A grant is held for a whole message and is released on the last byte, on the burst limit or on an idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [7:0]      burst_cnt, burst_d, burst_inc;
  logic [15:0]     idle_cnt, idle_d, idle_inc;
  logic [GW-1:0]   sel, cand;
  logic            found;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign burst_inc = burst_cnt + 8'd1;
  assign idle_inc  = idle_cnt + 16'd1;

  // Search starts just after the previous owner so it ends up with lowest priority.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = last_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + GW'(1);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      burst_cnt <= burst_d;
      idle_cnt  <= idle_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_cnt;
    idle_d  = idle_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          grant_d = sel;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      XFER: begin
        if (req_valid[grant_q]) begin
          idle_d = '0;
          if (tx_ready) begin
            burst_d = burst_inc;
            if (req_last[grant_q] || burst_inc == 8'(MAX_BURST)) begin
              state_d = RELEASE;
              last_d  = grant_q;
            end
          end
        end else begin
          idle_d = idle_inc;
          if (idle_inc == 16'(IDLE_TIMEOUT)) begin
            state_d = RELEASE;
            last_d  = grant_q;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so nothing is handed over on a reset cycle.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    busy      = 1'b0;
    grant_id  = grant_q;
    if (state == XFER && reset) begin
      tx_valid           = req_valid[grant_q];
      tx_data            = data_arr[grant_q];
      req_ready[grant_q] = tx_ready;
      busy               = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a per-cycle behavioural model of grant ownership.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_ready, busy;
  logic [0:0]      grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Source queues: bits [7:0] data, bit 8 marks the last byte of a message.
  int q [N][$];
  bit [N-1:0] pause, holding;
  int log_own[$], log_dat[$], log_cyc[$];
  int busy_hist[$];
  int cyc = 0;

  // Reference model: who owns the channel, whether it is in its gap cycle, and its counters.
  int m_owner = -1;
  bit m_rel   = 0;
  int m_last  = N - 1;
  int m_cnt   = 0;
  int m_idle  = 0;

  task automatic drive();
    int tmp;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = 1'b0;
      req_last[i]         = 1'b0;
      req_data[i*DW +: DW] = '0;
      if (q[i].size() > 0 && (holding[i] || !pause[i])) begin
        tmp                  = q[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = tmp[7:0];
        req_last[i]          = tmp[8];
      end
    end
  endtask

  task automatic step();
    logic         e_busy;
    logic [N-1:0] e_rdy, rdy_s;
    int o;
    #1;
    e_busy = reset && m_owner >= 0 && !m_rel;
    e_rdy  = '0;
    o      = (m_owner >= 0) ? m_owner : 0;
    check("busy", busy, e_busy);
    check("grant_id", grant_id, o);
    if (e_busy) begin
      e_rdy[o] = tx_ready;
      check("tx_valid", tx_valid, req_valid[o]);
      if (req_valid[o]) check("tx_data", tx_data, req_data[o*DW +: DW]);
    end else begin
      check("tx_valid_idle", tx_valid, 0);
    end
    check("req_ready", req_ready, e_rdy);
    busy_hist.push_back(busy);
    rdy_s = req_ready;
    if (tx_valid && tx_ready) begin
      log_own.push_back(grant_id);
      log_dat.push_back(tx_data);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      holding[i] = req_valid[i] && !rdy_s[i];
      if (req_valid[i] && rdy_s[i]) void'(q[i].pop_front());
    end
    if (!reset) begin
      m_owner = -1; m_rel = 0; m_last = N - 1; m_cnt = 0; m_idle = 0;
    end else if (m_rel) begin
      m_owner = -1; m_rel = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c; m_cnt = 0; m_idle = 0;
        end
      end
    end else if (req_valid[m_owner] && tx_ready) begin
      m_cnt++; m_idle = 0;
      if (req_last[m_owner] || m_cnt == MB) begin m_rel = 1; m_last = m_owner; end
    end else if (!req_valid[m_owner]) begin
      m_idle++;
      if (m_idle == TO) begin m_rel = 1; m_last = m_owner; end
    end else begin
      m_idle = 0;
    end
    cyc++;
    @(negedge clk);
    drive();
  endtask

  task automatic clear_logs();
    log_own.delete(); log_dat.delete(); log_cyc.delete(); busy_hist.delete();
  endtask

  initial begin
    int exp_o[12];
    int exp_d[12];
    int c0, cb, n;
    reset = 1'b0; tx_ready = 1'b1; pause = '0; holding = '0;
    @(negedge clk);

    // Reset held with both requesters valid, then message lock ("HI\n" from 0, then 1).
    q[0].push_back('h48); q[0].push_back('h49); q[0].push_back('h10A);
    q[1].push_back('h31); q[1].push_back('h132);
    drive();
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_txv", tx_valid, 0);
    reset = 1'b1;
    clear_logs();
    step();
    check("rst_first_grant", grant_id, 0);
    check("rst_txv_2nd", tx_valid, 1);
    repeat (12) step();
    exp_o = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    exp_d = '{'h48, 'h49, 'h0A, 'h31, 'h32, 0, 0, 0, 0, 0, 0, 0};
    check("hi_count", log_own.size(), 5);
    for (int k = 0; k < 5 && k < log_own.size(); k++) begin
      check("hi_owner", log_own[k], exp_o[k]);
      check("hi_data", log_dat[k], exp_d[k]);
    end
    if (log_cyc.size() >= 4) check("hi_gap", log_cyc[3] - log_cyc[2], 3);

    // Burst limit: 10 bytes from 0 without last, 1 pending.
    for (int k = 0; k < 10; k++) q[0].push_back('hA0 + k);
    q[1].push_back('h51); q[1].push_back('h152);
    drive();
    clear_logs();
    repeat (40) step();
    exp_o = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    exp_d = '{'hA0, 'hA1, 'hA2, 'hA3, 'h51, 'h52, 'hA4, 'hA5, 'hA6, 'hA7, 'hA8, 'hA9};
    check("burst_count", log_own.size(), 12);
    for (int k = 0; k < 12 && k < log_own.size(); k++) begin
      check("burst_owner", log_own[k], exp_o[k]);
      check("burst_data", log_dat[k], exp_d[k]);
    end

    // Idle timeout: owner sends one byte without last and goes quiet, the other waits.
    q[1].push_back('h77);
    q[0].push_back('h101);
    drive();
    clear_logs();
    c0 = cyc;
    repeat (20) step();
    check("to_count", log_own.size(), 2);
    if (log_own.size() >= 2) begin
      check("to_owner0", log_own[0], 1);
      check("to_owner1", log_own[1], 0);
      check("to_regrant", log_cyc[1] - log_cyc[0], 11);
      cb = log_cyc[0] - c0;
      check("to_busy_held", busy_hist[cb + TO], 1);
      check("to_busy_fall", busy_hist[cb + TO + 1], 0);
    end

    // Backpressure mid-message.
    q[0].push_back('hC1); q[0].push_back('hC2); q[0].push_back('h1C3);
    drive();
    clear_logs();
    n = 0;
    while (log_own.size() < 1 && n < 10) begin step(); n++; end
    check("bp_start", log_own.size(), 1);
    tx_ready = 1'b0;
    repeat (20) begin
      step();
      check("bp_data_stable", tx_data, 'hC2);
      check("bp_busy", busy, 1);
    end
    check("bp_no_xfer", log_own.size(), 1);
    tx_ready = 1'b1;
    repeat (6) step();
    check("bp_done", log_own.size(), 3);
    if (log_own.size() >= 3) check("bp_last", log_dat[2], 'hC3);

    // Reset in the middle of requester 1's message.
    for (int k = 0; k < 4; k++) q[1].push_back('hD0 + k);
    q[1].push_back('h1D4);
    drive();
    clear_logs();
    n = 0;
    while (log_own.size() < 2 && n < 10) begin step(); n++; end
    check("mr_start", log_own.size(), 2);
    q[0].push_back('h1E0);
    drive();
    reset = 1'b0;
    step();
    check("mr_busy", busy, 0);
    check("mr_ready", req_ready, 0);
    reset = 1'b1;
    step();
    check("mr_prio", grant_id, 0);
    repeat (15) step();
    if (log_own.size() >= 3) begin
      check("mr_owner", log_own[2], 0);
      check("mr_data", log_dat[2], 'hE0);
    end else begin
      check("mr_count", log_own.size(), 3);
    end

    // Random traffic with stalls, pauses and occasional reset.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 4 && $urandom_range(7) == 0) begin
          int len;
          bit lst;
          len = $urandom_range(1, 6);
          lst = ($urandom_range(3) != 0);
          for (int k = 0; k < len; k++)
            q[i].push_back(int'($urandom_range(255)) | ((lst && k == len - 1) ? 'h100 : 0));
        end
        pause[i] = ($urandom_range(5) == 0);
      end
      tx_ready = ($urandom_range(3) != 0);
      reset    = ($urandom_range(299) != 0);
      drive();
      step();
    end

    reset = 1'b1; tx_ready = 1'b1; pause = '0;
    drive();
    n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && n < 300) begin step(); n++; end
    check("drain", q[0].size() + q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
